// File: rtl/imem_boot_loader_if.sv
// Byte-receive and instruction-memory write bundle for imem_boot_loader.
//   rx_valid/rx_data  : byte source -> loader
//   rx_ready          : loader -> byte source (state decode, not registered)
//   imem_we/addr/wdata: loader -> instruction memory write port
// master = source/memory side, slave = loader side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image, writes it
// as little-endian 32-bit words into instruction memory, and holds the core
// in reset until a complete image with a matching checksum has been written.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : rx_valid/rx_data/rx_ready byte input, imem_we/addr/wdata
//   core_rst_n  : active-low core reset, released only after a good load
//   busy        : a load is in progress
//   done        : image loaded and verified (sticky until rst_n)
//   err         : last load failed
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [15:0]       r_n;
  logic [15:0]       r_word_cnt;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_buf;
  logic [7:0]        r_sum;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst_n;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_n_full;
  logic              w_oversize;
  logic              w_n_zero;
  logic              w_last_word;
  logic              w_word_end;
  logic              w_chk_ok;

  assign w_ready     = (r_state != S_DONE);
  assign w_accept    = bus.rx_valid && w_ready;
  // Full count as it will look once the high byte currently on rx_data is latched.
  assign w_n_full    = {bus.rx_data, r_n[7:0]};
  assign w_oversize  = ({1'b0, w_n_full} > MAX_W17);
  assign w_n_zero    = (w_n_full == 16'd0);
  assign w_last_word = (r_word_cnt == (r_n - 16'd1));
  assign w_word_end  = (r_byte_idx == 2'd3);
  assign w_chk_ok    = (bus.rx_data == r_sum);

  assign bus.rx_ready   = w_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_rst_n     = r_core_rst_n;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LEN_LO;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LEN_LO, S_ERR: if (w_accept) w_state_nxt = S_LEN_HI;
      S_LEN_HI: begin
        if (w_accept) begin
          if (w_oversize)    w_state_nxt = S_ERR;
          else if (w_n_zero) w_state_nxt = S_CHK;
          else               w_state_nxt = S_DATA;
        end
      end
      S_DATA: if (w_accept && w_word_end && w_last_word) w_state_nxt = S_CHK;
      S_CHK: begin
        if (w_accept) w_state_nxt = w_chk_ok ? S_DONE : S_ERR;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n          <= '0;
      r_word_cnt   <= '0;
      r_byte_idx   <= '0;
      r_buf        <= '0;
      r_sum        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          S_LEN_LO, S_ERR: begin
            r_n    <= {8'h00, bus.rx_data};
            r_busy <= 1'b1;
            r_err  <= 1'b0;
          end
          S_LEN_HI: begin
            r_n        <= w_n_full;
            r_word_cnt <= '0;
            r_byte_idx <= '0;
            r_sum      <= '0;
            if (w_oversize) begin
              r_err  <= 1'b1;
              r_busy <= 1'b0;
            end
          end
          S_DATA: begin
            r_sum      <= r_sum + bus.rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            unique case (r_byte_idx)
              2'd0: r_buf[7:0]   <= bus.rx_data;
              2'd1: r_buf[15:8]  <= bus.rx_data;
              2'd2: r_buf[23:16] <= bus.rx_data;
              default: begin
                // Fourth byte goes straight into the output word, no buffer stage.
                r_wdata    <= {bus.rx_data, r_buf};
                r_addr     <= r_word_cnt[ADDR_W-1:0];
                r_we       <= 1'b1;
                r_word_cnt <= r_word_cnt + 16'd1;
              end
            endcase
          end
          S_CHK: begin
            r_busy <= 1'b0;
            if (w_chk_ok) begin
              r_done       <= 1'b1;
              r_core_rst_n <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  typedef logic [7:0]          bq_t[$];
  typedef logic [ADDR_W+31:0]  wq_t[$];

  logic clk;
  logic rst_n;
  logic core_rst_n, busy, done, err;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  wq_t obs_q;
  wq_t exp_w;
  bit  exp_f[$];
  bit  exp_done, exp_err, exp_busy;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) obs_q.push_back({bus.imem_addr, bus.imem_wdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: parse the byte stream load by load, computing the writes,
  // which byte triggers each write, and the final status flags.
  function automatic void run_model(input bq_t s);
    int unsigned p;
    int unsigned n;
    logic [7:0]  sum;
    logic [31:0] word;
    exp_w.delete();
    exp_f.delete();
    for (int unsigned i = 0; i < s.size(); i++) exp_f.push_back(1'b0);
    exp_done = 0; exp_err = 0; exp_busy = 0;
    p = 0;
    while (p < s.size()) begin
      exp_err = 0; exp_busy = 1;
      if (p + 2 > s.size()) return;
      n = {s[p+1], s[p]};
      p += 2;
      if (n > MAX_WORDS) begin
        exp_err = 1; exp_busy = 0;
        continue;
      end
      sum = 8'd0;
      for (int unsigned k = 0; k < n; k++) begin
        word = 32'd0;
        for (int unsigned j = 0; j < 4; j++) begin
          if (p >= s.size()) return;
          word[8*j +: 8] = s[p];
          sum = sum + s[p];
          p++;
        end
        exp_w.push_back({ADDR_W'(k), word});
        exp_f[p-1] = 1'b1;
      end
      if (p >= s.size()) return;
      exp_busy = 0;
      if (s[p] == sum) begin
        exp_done = 1;
        return;
      end
      exp_err = 1;
      p++;
    end
  endfunction

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs_q.delete();
  endtask

  // Called and returns at a negedge; the byte is taken at the posedge in between.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      chk("rx_ready_timeout", {63'd0, bus.rx_ready}, 64'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic send_stream(input bq_t s, input int unsigned gapmax);
    run_model(s);
    for (int unsigned i = 0; i < s.size(); i++) begin
      send_byte(s[i], (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
      chk("we_timing", {63'd0, bus.imem_we}, {63'd0, exp_f[i]});
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_done"},  {63'd0, done},       {63'd0, exp_done});
    chk({tag, "_core"},  {63'd0, core_rst_n}, {63'd0, exp_done});
    chk({tag, "_err"},   {63'd0, err},        {63'd0, exp_err});
    chk({tag, "_busy"},  {63'd0, busy},       {63'd0, exp_busy});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_w.size()));
    for (int unsigned i = 0; i < exp_w.size() && i < obs_q.size(); i++)
      chk({tag, "_wr_entry"}, 64'(obs_q[i]), 64'(exp_w[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {63'd0, bus.rx_ready}, 64'd1);
    chk({tag, "_we"},       {63'd0, bus.imem_we},  64'd0);
    chk({tag, "_addr"},     64'(bus.imem_addr),    64'd0);
    chk({tag, "_wdata"},    64'(bus.imem_wdata),   64'd0);
    chk({tag, "_core"},     {63'd0, core_rst_n},   64'd0);
    chk({tag, "_busy"},     {63'd0, busy},         64'd0);
    chk({tag, "_done"},     {63'd0, done},         64'd0);
    chk({tag, "_err"},      {63'd0, err},          64'd0);
  endtask

  bq_t nominal, bad, s, part;
  int unsigned wr_before;

  initial begin
    nominal = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h07};
    bad     = nominal;
    bad[10] = 8'h08;

    // Reset values
    do_reset();
    check_reset_outputs("reset");

    // Nominal, back-to-back
    send_stream(nominal, 0);
    check_status("nominal");
    check_writes("nominal");
    chk("nominal_w0", 64'(obs_q[0]), {22'd0, 10'd0, 32'h00500093});
    chk("nominal_w1", 64'(obs_q[1]), {22'd0, 10'd1, 32'h00100113});

    // Bad checksum, then correct retransmission
    do_reset();
    send_stream(bad, 0);
    check_status("badchk");
    check_writes("badchk");
    chk("badchk_err_const", {63'd0, err}, 64'd1);
    obs_q.delete();
    send_stream(nominal, 0);
    check_status("retx");
    check_writes("retx");

    // Zero length
    do_reset();
    send_stream('{8'h00, 8'h00, 8'h00}, 0);
    check_status("zero_ok");
    check_writes("zero_ok");
    do_reset();
    send_stream('{8'h00, 8'h00, 8'h01}, 0);
    check_status("zero_bad");
    check_writes("zero_bad");

    // Oversize count; following byte starts a new load
    do_reset();
    send_stream('{8'h01, 8'h04}, 0);
    check_status("oversize");
    chk("oversize_err_const", {63'd0, err}, 64'd1);
    check_writes("oversize");
    send_stream(nominal, 0);
    check_status("after_oversize");
    check_writes("after_oversize");

    // Stalls, then bytes presented in DONE
    do_reset();
    send_stream(nominal, 7);
    check_status("stall");
    check_writes("stall");
    wr_before = obs_q.size();
    bus.rx_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      bus.rx_data = 8'($urandom);
      @(negedge clk);
      chk("done_rx_ready", {63'd0, bus.rx_ready}, 64'd0);
    end
    bus.rx_valid = 1'b0;
    chk("done_no_writes", 64'(obs_q.size()), 64'(wr_before));
    check_status("done_hold");

    // Mid-load reset after the 6th byte (a write strobe is pending)
    do_reset();
    part = nominal[0:5];
    send_stream(part, 0);
    chk("midrst_we_pending", {63'd0, bus.imem_we}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obs_q.delete();
    send_stream(nominal, 0);
    check_status("midrst_reload");
    check_writes("midrst_reload");

    // Random loads: one or two loads per stream, checksums randomly corrupted
    for (int unsigned it = 0; it < 8; it++) begin
      do_reset();
      s.delete();
      for (int unsigned ld = 0; ld < 1 + (it % 2); ld++) begin
        int unsigned n;
        logic [7:0]  sum, b;
        n = $urandom_range(1, 5);
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        sum = 8'd0;
        for (int unsigned i = 0; i < 4 * n; i++) begin
          b = 8'($urandom);
          s.push_back(b);
          sum = sum + b;
        end
        if (ld == 0 && (it % 2) == 1) s.push_back(sum ^ 8'h5A);
        else s.push_back(($urandom_range(0, 1) == 1) ? sum : sum + 8'd1);
      end
      send_stream(s, 3);
      check_status("random");
      check_writes("random");
    end

    // Largest accepted image: N == MAX_WORDS, fills every address
    do_reset();
    begin
      logic [7:0] sum, b;
      s.delete();
      s.push_back(8'(MAX_WORDS));
      s.push_back(8'(MAX_WORDS >> 8));
      sum = 8'd0;
      for (int unsigned i = 0; i < 4 * MAX_WORDS; i++) begin
        b = 8'($urandom);
        s.push_back(b);
        sum = sum + b;
      end
      s.push_back(sum);
    end
    send_stream(s, 0);
    check_status("maxwords");
    check_writes("maxwords");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
